// File: rtl/seq_restoring_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst (async, active high), start
//   x (dividend), y (divisor)
//   busy, done (1-cycle pulse), q, r, div_by_zero
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             zf;

  // Shifted partial remainder keeps the bit pulled out of qsr, so the
  // trial subtraction is WIDTH+1 wide; its MSB is the borrow/sign.
  logic [WIDTH:0] rs;
  logic [WIDTH:0] trial;

  always_comb begin
    rs    = {rem, qsr[WIDTH-1]};
    trial = rs - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      qsr         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      zf          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !busy) begin
            qsr         <= x;
            dvs         <= y;
            rem         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            zf          <= (y == '0);
            state       <= (y == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          // Negative trial: restore the shifted remainder, quotient bit 0.
          rem   <= trial[WIDTH] ? rs[WIDTH-1:0] : trial[WIDTH-1:0];
          qsr   <= {qsr[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          if (zf) begin
            // qsr still holds the untouched dividend on this path.
            q           <= '1;
            r           <= qsr;
            div_by_zero <= 1'b1;
          end else begin
            q <= qsr;
            r <= rem;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
